// File: rtl/time_formatter.sv
// Converts an elapsed-seconds count into MM:SS BCD digits for the display controller.
// Iterative divide-by-60 followed by parallel double-dabble; digits update atomically.
module time_formatter #(
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sec_count,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic        busy,
    output logic        update
);

    typedef enum logic [1:0] {StIdle, StDiv, StBcd, StCommit} state_e;

    localparam logic [3:0] Digit3Rst = BLANK_LEADING ? 4'hF : 4'h0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] sync1_q, sync2_q;
    logic [11:0] last_q, last_d;
    logic [11:0] quo_q, quo_d;
    logic [6:0]  rem_q, rem_d;
    logic [14:0] min_sr_q, min_sr_d;
    logic [14:0] sec_sr_q, sec_sr_d;
    logic [3:0]  d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [6:0]  trial;

    // One double-dabble iteration: adjust BCD nibbles, then shift the whole register left.
    function automatic logic [14:0] dd_step(input logic [14:0] sr);
        logic [14:0] s;
        s = sr;
        if (s[10:7] >= 4'd5) s[10:7] = s[10:7] + 4'd3;
        if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
        return {s[13:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            sync1_q  <= 12'd0;
            sync2_q  <= 12'd0;
            last_q   <= 12'd0;
            quo_q    <= 12'd0;
            rem_q    <= 7'd0;
            min_sr_q <= 15'd0;
            sec_sr_q <= 15'd0;
            d3_q     <= Digit3Rst;
            d2_q     <= 4'd0;
            d1_q     <= 4'd0;
            d0_q     <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= sec_count;
            sync2_q  <= sync1_q;
            last_q   <= last_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            min_sr_q <= min_sr_d;
            sec_sr_q <= sec_sr_d;
            d3_q     <= d3_d;
            d2_q     <= d2_d;
            d1_q     <= d1_d;
            d0_q     <= d0_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        min_sr_d = min_sr_q;
        sec_sr_d = sec_sr_q;
        d3_d     = d3_q;
        d2_d     = d2_q;
        d1_d     = d1_q;
        d0_d     = d0_q;
        trial    = {rem_q[5:0], quo_q[11]};

        unique case (state_q)
            StIdle: begin
                if (sync1_q == sync2_q && sync2_q != last_q) begin
                    quo_d   = sync2_q;
                    last_d  = sync2_q;
                    rem_d   = 7'd0;
                    cnt_d   = 4'd0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                // Dividend bits shift out of quo_q's top while quotient bits enter its bottom.
                if (trial >= 7'd60) begin
                    rem_d = trial - 7'd60;
                    quo_d = {quo_q[10:0], 1'b1};
                end else begin
                    rem_d = trial;
                    quo_d = {quo_q[10:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    cnt_d    = 4'd0;
                    min_sr_d = {8'd0, quo_d[6:0]};
                    sec_sr_d = {8'd0, rem_d};
                    state_d  = StBcd;
                end
            end
            StBcd: begin
                min_sr_d = dd_step(min_sr_q);
                sec_sr_d = dd_step(sec_sr_q);
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd6) begin
                    cnt_d   = 4'd0;
                    state_d = StCommit;
                end
            end
            StCommit: begin
                d3_d    = (BLANK_LEADING && min_sr_q[14:11] == 4'd0) ? 4'hF : min_sr_q[14:11];
                d2_d    = min_sr_q[10:7];
                d1_d    = sec_sr_q[14:11];
                d0_d    = sec_sr_q[10:7];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q != StIdle);
    assign update = (state_q == StCommit);
    assign digit3 = d3_q;
    assign digit2 = d2_q;
    assign digit1 = d1_q;
    assign digit0 = d0_q;

endmodule

// File: tb/tb_time_formatter.sv
// Self-checking bench for time_formatter: two instances (plain and leading-blank)
// checked against an arithmetic MM:SS model.
module tb_time_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sec_count;
    logic [3:0]  a3, a2, a1, a0, b3, b2, b1, b0;
    logic        a_busy, a_upd, b_busy, b_upd;
    logic [15:0] a_dig, b_dig;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign a_dig = {a3, a2, a1, a0};
    assign b_dig = {b3, b2, b1, b0};

    time_formatter #(.BLANK_LEADING(1'b0)) dut_a (
        .clk(clk), .rst(rst), .sec_count(sec_count),
        .digit3(a3), .digit2(a2), .digit1(a1), .digit0(a0),
        .busy(a_busy), .update(a_upd)
    );

    time_formatter #(.BLANK_LEADING(1'b1)) dut_b (
        .clk(clk), .rst(rst), .sec_count(sec_count),
        .digit3(b3), .digit2(b2), .digit1(b1), .digit0(b0),
        .busy(b_busy), .update(b_upd)
    );

    // Expected display for v seconds: minutes = v/60, seconds = v%60, as four BCD digits.
    function automatic logic [15:0] model(input int v, input bit blank);
        int m, s, t;
        m = v / 60;
        s = v % 60;
        t = m / 10;
        if (blank && t == 0) t = 15;
        return {t[3:0], 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic test_reset();
        bit saw = 1'b0;
        rst = 1'b0;
        sec_count = 12'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (a_busy || a_upd || b_busy || b_upd) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++; $display("FAIL reset_activity: got busy/update asserted, required none");
        end
        n_cmp++;
        if (a_dig !== 16'h0000) begin
            n_bad++; $display("FAIL reset_digits: got %h required 0000", a_dig);
        end
        n_cmp++;
        if (b_dig !== 16'hF000) begin
            n_bad++; $display("FAIL reset_digits_blank: got %h required f000", b_dig);
        end
    endtask

    task automatic test_step_75();
        int t_busy = -1;
        int t_upd = -1;
        int ups = 0;
        bit early = 1'b0;
        sec_count = 12'd75;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (t_upd < 0 && a_dig !== 16'h0000) early = 1'b1;
            if (a_busy && t_busy < 0) t_busy = i;
            if (a_upd) begin
                ups++;
                if (t_upd < 0) t_upd = i;
            end
        end
        n_cmp++;
        if (ups !== 1) begin
            n_bad++; $display("FAIL step75_updates: got %0d required 1", ups);
        end
        n_cmp++;
        if (t_busy < 3 || t_busy > 4) begin
            n_bad++; $display("FAIL step75_busy_latency: got %0d required 3..4", t_busy);
        end
        n_cmp++;
        if (t_upd - t_busy !== 19) begin
            n_bad++; $display("FAIL step75_update_latency: got %0d required 19", t_upd - t_busy);
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++; $display("FAIL step75_early_change: got early digit change, required none");
        end
        n_cmp++;
        if (a_dig !== model(75, 1'b0)) begin
            n_bad++; $display("FAIL step75_digits: got %h required %h", a_dig, model(75, 1'b0));
        end
        n_cmp++;
        if (b_dig !== model(75, 1'b1)) begin
            n_bad++; $display("FAIL step75_blank: got %h required %h", b_dig, model(75, 1'b1));
        end
    endtask

    task automatic test_boundaries();
        int vals[6] = '{59, 60, 3599, 3600, 4095, 600};
        for (int k = 0; k < 6; k++) begin
            int ups = 0;
            sec_count = 12'(vals[k]);
            repeat (50) begin
                @(negedge clk);
                if (a_upd) ups++;
            end
            n_cmp++;
            if (ups !== 1) begin
                n_bad++; $display("FAIL bound_updates_%0d: got %0d required 1", vals[k], ups);
            end
            n_cmp++;
            if (a_dig !== model(vals[k], 1'b0)) begin
                n_bad++;
                $display("FAIL bound_%0d: got %h required %h", vals[k], a_dig,
                         model(vals[k], 1'b0));
            end
            n_cmp++;
            if (b_dig !== model(vals[k], 1'b1)) begin
                n_bad++;
                $display("FAIL bound_blank_%0d: got %h required %h", vals[k], b_dig,
                         model(vals[k], 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] caps[$];
        int ups = 0;
        bit pend = 1'b0;
        bit got_busy = 1'b0;
        sec_count = 12'd100;
        for (int i = 0; i < 10 && !got_busy; i++) begin
            @(negedge clk);
            if (a_busy) got_busy = 1'b1;
        end
        n_cmp++;
        if (got_busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy: got no busy within 10 clocks, required busy");
        end
        repeat (4) @(negedge clk);
        sec_count = 12'd200;
        repeat (80) begin
            @(negedge clk);
            if (pend) begin
                caps.push_back(a_dig);
                pend = 1'b0;
            end
            if (a_upd) begin
                ups++;
                pend = 1'b1;
            end
        end
        n_cmp++;
        if (ups !== 2) begin
            n_bad++; $display("FAIL b2b_updates: got %0d required 2", ups);
        end
        if (caps.size() >= 2) begin
            n_cmp++;
            if (caps[0] !== model(100, 1'b0)) begin
                n_bad++; $display("FAIL b2b_first: got %h required %h", caps[0], model(100, 1'b0));
            end
            n_cmp++;
            if (caps[1] !== model(200, 1'b0)) begin
                n_bad++; $display("FAIL b2b_second: got %h required %h", caps[1], model(200, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int ups = 0;
        bit got_busy = 1'b0;
        sec_count = 12'd500;
        for (int i = 0; i < 10 && !got_busy; i++) begin
            @(negedge clk);
            if (a_busy) got_busy = 1'b1;
        end
        n_cmp++;
        if (got_busy !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_busy: got no busy within 10 clocks, required busy");
        end
        // Busy rises in the first divide cycle; 15 clocks later the block is mid-BCD.
        repeat (15) begin
            @(negedge clk);
            if (a_upd) ups++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (a_upd) ups++;
        n_cmp++;
        if (a_dig !== 16'h0000 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_clear: got %h busy %b required 0000 busy 0", a_dig, a_busy);
        end
        n_cmp++;
        if (b_dig !== 16'hF000) begin
            n_bad++; $display("FAIL rstmid_clear_blank: got %h required f000", b_dig);
        end
        n_cmp++;
        if (ups !== 0) begin
            n_bad++; $display("FAIL rstmid_no_update: got %0d required 0", ups);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (a_upd) ups++;
        end
        n_cmp++;
        if (ups !== 1) begin
            n_bad++; $display("FAIL rstmid_restart_updates: got %0d required 1", ups);
        end
        n_cmp++;
        if (a_dig !== model(500, 1'b0)) begin
            n_bad++; $display("FAIL rstmid_restart: got %h required %h", a_dig, model(500, 1'b0));
        end
    endtask

    task automatic test_random();
        int cur = 500;
        for (int k = 0; k < 10; k++) begin
            int v;
            int ups = 0;
            v = int'($urandom_range(0, 4095));
            if (v == cur) v = (v + 1) % 4096;
            cur = v;
            sec_count = 12'(v);
            repeat (30) begin
                @(negedge clk);
                if (a_upd) ups++;
            end
            n_cmp++;
            if (ups !== 1) begin
                n_bad++; $display("FAIL rand_updates_%0d: got %0d required 1", v, ups);
            end
            n_cmp++;
            if (a_dig !== model(v, 1'b0) || b_dig !== model(v, 1'b1)) begin
                n_bad++;
                $display("FAIL rand_%0d: got %h/%h required %h/%h", v, a_dig, b_dig,
                         model(v, 1'b0), model(v, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_75();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
